regfile_checker: RTL and testbench
==================================

REGFILE_CHECKER -- requirements
Module: regfile_checker

Interface
REQ-001 SHALL have parameter XLEN, default 32: register and expected-value width.
REQ-002 SHALL have parameter NREGS, default 32: number of registers checked, power of two, at least 2.
REQ-003 SHALL have parameter SENT_VAL, default 32'h0000C0DE: completion value watched on sentinel.
REQ-004 SHALL have parameter TIMEOUT, default 50: maximum WAIT cycles, at least 1.
REQ-005 SHALL have ports clk in 1 (rising-edge clock) and reset in 1; one clock; reset is asynchronous and active-low (0 = reset).
REQ-006 SHALL have port start in 1: arm request.
REQ-007 SHALL have port sentinel in XLEN: live value of the CPU sentinel register.
REQ-008 SHALL have ports exp_we in 1, exp_idx in log2(NREGS), exp_data in XLEN and exp_chk in 1, forming the expected-table write (exp_chk 1 = compare the entry, 0 = skip it).
REQ-009 SHALL have ports rf_raddr out log2(NREGS) and rf_rdata in XLEN, forming the CPU register debug read; rf_rdata is combinational from rf_raddr in the same cycle.
REQ-010 SHALL have ports busy out 1, done out 1, pass out 1 and timeout out 1.
REQ-011 SHALL have port mismatch_cnt out log2(NREGS)+1.
REQ-012 SHALL have ports first_idx out log2(NREGS), first_exp out XLEN and first_act out XLEN, holding the lowest mismatching entry.

Function
REQ-013 SHALL hold an internal table of NREGS entries {data, chk}; on exp_we, the table SHALL write exp_idx at the clock edge, in any state.
REQ-014 SHALL implement the FSM IDLE, WAIT, CHECK and DONE; busy = 1 in WAIT and CHECK.
REQ-015 IDLE SHALL go to WAIT on start=1, clearing the cycle counter, mismatch_cnt, timeout, done, pass and the first_* outputs.
REQ-016 WAIT SHALL count cycles; on sentinel == SENT_VAL it SHALL go to CHECK with idx = 0.
REQ-017 WAIT SHALL set timeout = 1 and go to CHECK when TIMEOUT cycles elapse with no match; a match in the final counted cycle SHALL take priority, leaving timeout = 0.
REQ-018 In CHECK, each cycle SHALL set rf_raddr = idx; if the table chk bit for idx is 1 and rf_rdata != data, mismatch_cnt SHALL increment.
REQ-019 In CHECK, first_idx, first_exp and first_act SHALL capture only the first mismatch.
REQ-020 In CHECK, idx SHALL increment by 1 per cycle, and the FSM SHALL go to DONE after idx = NREGS-1, with no wrap.
REQ-021 The comparison SHALL use the table value before any same-cycle exp_we write to the same entry.
REQ-022 Latency: sentinel match sampled at edge k gives CHECK idx 0 in cycle k+1 and done = 1 after edge k+NREGS; one register is checked per cycle.
REQ-023 DONE SHALL hold done = 1, with pass = (mismatch_cnt == 0) AND (timeout == 0), both held until re-armed.
REQ-024 start=1 in DONE SHALL re-arm exactly as from IDLE; start SHALL be ignored in WAIT and CHECK.
REQ-025 mismatch_cnt SHALL count to NREGS (all mismatch) without saturation or overflow.
REQ-026 rf_raddr SHALL be 0 outside CHECK; x0 receives no special handling.
REQ-027 Outputs SHALL be registered, except rf_raddr, which is driven from the idx register.

Reset
REQ-028 reset = 0 SHALL asynchronously force IDLE, idx = 0 and counter = 0.
REQ-029 reset = 0 SHALL force busy = done = pass = timeout = 0, mismatch_cnt = 0, first_* = 0 and rf_raddr = 0.
REQ-030 reset = 0 SHALL clear every table entry to data = 0, chk = 0.
REQ-031 Reset asserted in WAIT or CHECK SHALL abort the run, with no done pulse and no partial result retained.
REQ-032 Operation SHALL resume on the first rising edge after reset deasserts.

Verification
REQ-033 Load all 32 entries with chk = 1 matching the model regfile; start; sentinel = C0DE at cycle 5 -> CHECK at cycle 6, done after 32 cycles, pass = 1, mismatch_cnt = 0, timeout = 0.
REQ-034 Corrupt the model regs x7 (exp 5, act 6) and x20 -> mismatch_cnt = 2, first_idx = 7, first_exp = 5, first_act = 6, pass = 0.
REQ-035 Sentinel never matches, TIMEOUT = 50 -> timeout = 1 after 50 WAIT cycles; the check still runs; pass = 0 even with all registers matching.
REQ-036 Set x3 chk = 0 with a wrong value, plus a same-cycle exp_we to the entry being compared -> x3 is ignored and the compare uses the old table value.
REQ-037 Assert reset mid-CHECK at idx = 10 -> all outputs 0 and table cleared; start then sentinel match with an empty table -> pass = 1.
REQ-038 start held during WAIT/CHECK -> no restart; start in DONE -> results cleared and a new run proceeds.

Source files
------------

// File: rtl/regfile_checker_if.sv
// regfile_checker_if: checker control, expected-table write, register debug read and result bundle
interface regfile_checker_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);
  logic            start;
  logic [XLEN-1:0] sentinel;
  logic            exp_we;
  logic [AW-1:0]   exp_idx;
  logic [XLEN-1:0] exp_data;
  logic            exp_chk;
  logic [AW-1:0]   rf_raddr;
  logic [XLEN-1:0] rf_rdata;
  logic            busy;
  logic            done;
  logic            pass;
  logic            timeout;
  logic [AW:0]     mismatch_cnt;
  logic [AW-1:0]   first_idx;
  logic [XLEN-1:0] first_exp;
  logic [XLEN-1:0] first_act;
  modport master (
    output start, sentinel, exp_we, exp_idx, exp_data, exp_chk, rf_rdata,
    input  rf_raddr, busy, done, pass, timeout, mismatch_cnt, first_idx, first_exp, first_act
  );
  modport slave (
    input  start, sentinel, exp_we, exp_idx, exp_data, exp_chk, rf_rdata,
    output rf_raddr, busy, done, pass, timeout, mismatch_cnt, first_idx, first_exp, first_act
  );
endinterface

// File: rtl/regfile_checker.sv
// regfile_checker: waits for a sentinel value, then compares every CPU register against an expected table
module regfile_checker #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] SENT_VAL = 'h0000C0DE,
  parameter int              TIMEOUT  = 50
) (
  input logic clk,
  input logic reset,
  regfile_checker_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
  state_t          state, nxt;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   idx;
  logic [XLEN-1:0] tbl_data [NREGS];
  logic [NREGS-1:0] tbl_chk;
  logic            sent_hit, expired, last, hit, arm;
  logic [AW:0]     mis_nxt;
  assign sent_hit = bus.sentinel == SENT_VAL;
  assign expired  = cnt == CW'(TIMEOUT - 1);
  assign last     = idx == AW'(NREGS - 1);
  assign arm      = (state == IDLE || state == DONE) && bus.start;
  // Table read sees the pre-write value, so a same-cycle exp_we never affects the compare
  assign hit      = state == CHECK && tbl_chk[idx] && bus.rf_rdata != tbl_data[idx];
  assign mis_nxt  = bus.mismatch_cnt + {{AW{1'b0}}, hit};
  assign bus.rf_raddr = state == CHECK ? idx : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = arm ? WAIT
        : state == WAIT  ? ((sent_hit || expired) ? CHECK : WAIT)
        : state == CHECK ? (last ? DONE : CHECK)
        : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt              <= '0;
      idx              <= '0;
      tbl_chk          <= '0;
      for (int i = 0; i < NREGS; i++) tbl_data[i] <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.pass         <= 1'b0;
      bus.timeout      <= 1'b0;
      bus.mismatch_cnt <= '0;
      bus.first_idx    <= '0;
      bus.first_exp    <= '0;
      bus.first_act    <= '0;
    end else begin
      if (bus.exp_we) begin
        tbl_data[bus.exp_idx] <= bus.exp_data;
        tbl_chk[bus.exp_idx]  <= bus.exp_chk;
      end
      bus.busy <= nxt == WAIT || nxt == CHECK;
      if (arm) begin
        cnt              <= '0;
        idx              <= '0;
        bus.done         <= 1'b0;
        bus.pass         <= 1'b0;
        bus.timeout      <= 1'b0;
        bus.mismatch_cnt <= '0;
        bus.first_idx    <= '0;
        bus.first_exp    <= '0;
        bus.first_act    <= '0;
      end
      if (state == WAIT) begin
        cnt <= cnt + CW'(1);
        if (!sent_hit && expired) bus.timeout <= 1'b1;
      end
      if (state == CHECK) begin
        bus.mismatch_cnt <= mis_nxt;
        if (hit && bus.mismatch_cnt == '0) begin
          bus.first_idx <= idx;
          bus.first_exp <= tbl_data[idx];
          bus.first_act <= bus.rf_rdata;
        end
        idx <= last ? '0 : idx + AW'(1);
        if (last) begin
          bus.done <= 1'b1;
          bus.pass <= mis_nxt == '0 && !bus.timeout;
        end
      end
    end
endmodule

// File: tb/tb_regfile_checker.sv
// tb_regfile_checker: directed runs against a register model; expected results queued at start, checked at done
module tb_regfile_checker;
  localparam int XLEN = 32, NREGS = 32, TIMEOUT = 50, AW = 5;
  localparam logic [31:0] SENT = 32'h0000C0DE;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  regfile_checker_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();
  regfile_checker #(.XLEN(XLEN), .NREGS(NREGS), .SENT_VAL(SENT), .TIMEOUT(TIMEOUT))
    dut (.clk(clk), .reset(reset), .bus(bus.slave));
  logic [31:0] model_rf [NREGS];
  logic [31:0] tb_data  [NREGS];
  logic        tb_chk   [NREGS];
  assign bus.rf_rdata = model_rf[bus.rf_raddr];
  typedef struct packed {
    logic pass, to;
    logic [AW:0] mis;
    logic [AW-1:0] fidx;
    logic [31:0] fexp, fact;
  } res_t;
  res_t exp_q[$];
  int vectors = 0, miscompares = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int i, logic [31:0] d, logic c);
    bus.exp_we = 1'b1; bus.exp_idx = AW'(i); bus.exp_data = d; bus.exp_chk = c;
    tb_data[i] = d; tb_chk[i] = c;
    tick;
    bus.exp_we = 1'b0;
  endtask

  function automatic res_t predict(logic to);
    res_t r = '0;
    r.to = to;
    for (int i = 0; i < NREGS; i++)
      if (tb_chk[i] && model_rf[i] !== tb_data[i]) begin
        if (r.mis == 0) begin
          r.fidx = AW'(i); r.fexp = tb_data[i]; r.fact = model_rf[i];
        end
        r.mis = r.mis + 1'b1;
      end
    r.pass = r.mis == 0 && !to;
    return r;
  endfunction

  task automatic check_idle_outputs(string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_done"}, 64'(bus.done), 64'(0));
    check({tag, "_pass"}, 64'(bus.pass), 64'(0));
    check({tag, "_timeout"}, 64'(bus.timeout), 64'(0));
    check({tag, "_mis"}, 64'(bus.mismatch_cnt), 64'(0));
    check({tag, "_fidx"}, 64'(bus.first_idx), 64'(0));
    check({tag, "_fexp"}, 64'(bus.first_exp), 64'(0));
    check({tag, "_fact"}, 64'(bus.first_act), 64'(0));
    check({tag, "_raddr"}, 64'(bus.rf_raddr), 64'(0));
  endtask

  // dly: WAIT cycles before sentinel matches (<0 = never); hold keeps start high; wr_idx rewrites that entry while it is compared
  task automatic run(string tag, int dly, logic hold, int wr_idx);
    res_t r;
    int n, n_c, exp_n;
    n_c = dly < 0 ? TIMEOUT : dly + 1;
    exp_n = n_c + NREGS;
    exp_q.push_back(predict(dly < 0));
    bus.start = 1'b1;
    tick;
    if (!hold) bus.start = 1'b0;
    check({tag, "_armed_busy"}, 64'(bus.busy), 64'(1));
    check({tag, "_armed_done"}, 64'(bus.done), 64'(0));
    check({tag, "_armed_mis"}, 64'(bus.mismatch_cnt), 64'(0));
    check({tag, "_armed_fidx"}, 64'(bus.first_idx), 64'(0));
    check({tag, "_armed_timeout"}, 64'(bus.timeout), 64'(0));
    n = 0;
    if (dly == 0) bus.sentinel = SENT;
    while (!bus.done && n < 300) begin
      tick;
      n++;
      if (bus.exp_we) bus.exp_we = 1'b0;
      if (n == dly) bus.sentinel = SENT;
      if (n == n_c - 1) begin
        check({tag, "_wait_raddr"}, 64'(bus.rf_raddr), 64'(0));
        check({tag, "_wait_timeout"}, 64'(bus.timeout), 64'(0));
      end
      if (n == n_c) begin
        check({tag, "_chk0_busy"}, 64'(bus.busy), 64'(1));
        check({tag, "_chk0_timeout"}, 64'(bus.timeout), 64'(dly < 0));
      end
      if (n == n_c + 10) check({tag, "_chk10_raddr"}, 64'(bus.rf_raddr), 64'(10));
      if (wr_idx >= 0 && n == n_c + wr_idx) begin
        bus.exp_we = 1'b1; bus.exp_idx = AW'(wr_idx);
        bus.exp_data = ~tb_data[wr_idx]; bus.exp_chk = 1'b1;
        tb_data[wr_idx] = ~tb_data[wr_idx]; tb_chk[wr_idx] = 1'b1;
      end
    end
    bus.start = 1'b0; bus.sentinel = '0; bus.exp_we = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'(exp_n));
    r = exp_q.pop_front();
    check({tag, "_done"}, 64'(bus.done), 64'(1));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_pass"}, 64'(bus.pass), 64'(r.pass));
    check({tag, "_timeout"}, 64'(bus.timeout), 64'(r.to));
    check({tag, "_mis"}, 64'(bus.mismatch_cnt), 64'(r.mis));
    check({tag, "_fidx"}, 64'(bus.first_idx), 64'(r.fidx));
    check({tag, "_fexp"}, 64'(bus.first_exp), 64'(r.fexp));
    check({tag, "_fact"}, 64'(bus.first_act), 64'(r.fact));
    tick;
    check({tag, "_hold_done"}, 64'(bus.done), 64'(1));
    check({tag, "_hold_pass"}, 64'(bus.pass), 64'(r.pass));
    check({tag, "_hold_raddr"}, 64'(bus.rf_raddr), 64'(0));
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.sentinel = '0; bus.exp_we = 1'b0;
    bus.exp_idx = '0; bus.exp_data = '0; bus.exp_chk = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      model_rf[i] = 32'h1000_0000 + i * 32'h0101;
      tb_data[i] = '0; tb_chk[i] = 1'b0;
    end
    repeat (2) tick;
    check_idle_outputs("reset");
    reset = 1'b1;
    tick;
    for (int i = 0; i < NREGS; i++) wr(i, model_rf[i], 1'b1);
    run("match", 4, 1'b0, -1);
    wr(7, 32'd5, 1'b1);
    model_rf[7] = 32'd6;
    model_rf[20] = model_rf[20] ^ 32'h80;
    run("corrupt", 9, 1'b0, -1);
    model_rf[7] = 32'd5;
    model_rf[20] = model_rf[20] ^ 32'h80;
    run("timeout", -1, 1'b0, -1);
    run("last_cycle_hit", TIMEOUT - 1, 1'b0, -1);
    wr(3, 32'hDEAD_BEEF, 1'b0);
    run("skip_x3_same_cycle_we", 2, 1'b0, 12);
    run("after_we", 2, 1'b0, -1);
    wr(12, model_rf[12], 1'b1);
    wr(3, model_rf[3], 1'b1);
    for (int i = 0; i < NREGS; i++) model_rf[i] = ~model_rf[i];
    run("all_bad_start_held", 0, 1'b1, -1);
    for (int i = 0; i < NREGS; i++) model_rf[i] = ~model_rf[i];
    run("rearm_from_done", 1, 1'b0, -1);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.sentinel = SENT;
    n = 0;
    while (bus.rf_raddr != AW'(10) && n < 100) begin
      tick;
      n++;
    end
    bus.sentinel = '0;
    check("rst_reached_idx10", 64'(n < 100), 64'(1));
    #1 reset = 1'b0;
    #1 check_idle_outputs("async_reset");
    for (int i = 0; i < NREGS; i++) begin
      tb_data[i] = '0; tb_chk[i] = 1'b0;
    end
    repeat (3) tick;
    check("rst_no_done", 64'(bus.done), 64'(0));
    #2 reset = 1'b1;
    tick;
    check_idle_outputs("post_reset");
    run("empty_table", 3, 1'b0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
